// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style memory port between
// the instruction-fetch and load/store masters, with an ack watchdog.
module core_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                    clk_core,
  input  logic                    rst_core,

  input  logic                    ifu_cyc,
  input  logic                    ifu_stb,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic [DATA_WIDTH-1:0]   ifu_data_in,
  output logic                    ifu_ack,

  input  logic                    lsu_cyc,
  input  logic                    lsu_stb,
  input  logic                    lsu_we,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_data_out,
  output logic [DATA_WIDTH-1:0]   lsu_data_in,
  output logic                    lsu_ack,

  output logic                    mem_cyc,
  output logic                    mem_stb,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic                    mem_ack,

  output logic [1:0]              grant,
  output logic                    timeout_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            grant_d;
  logic                  last_lsu_q, last_lsu_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  to_d;
  logic                  cyc_d;
  logic                  we_d;
  logic [SW-1:0]         wstrb_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  logic                  ifu_req;
  logic                  lsu_req;
  logic                  pick_lsu;
  logic                  expire;
  logic                  done;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign ifu_req  = ifu_cyc & ifu_stb;
  assign lsu_req  = lsu_cyc & lsu_stb;
  // On a tie the master that was not served last wins
  assign pick_lsu = lsu_req & (~ifu_req | ~last_lsu_q);

  assign expire = WDOG_EN && (state_q == BUSY) &&
                  (cnt_q == CNT_LAST) && !mem_ack;
  assign done   = (state_q == BUSY) && (mem_ack || expire);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    last_lsu_d = last_lsu_q;
    cnt_d      = cnt_q;
    to_d       = timeout_o;
    cyc_d      = mem_cyc;
    we_d       = mem_we;
    wstrb_d    = mem_wstrb;
    addr_d     = mem_addr;
    wdata_d    = mem_data_out;
    unique case (state_q)
      IDLE: begin
        if (ifu_req || lsu_req) begin
          state_d = BUSY;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          unique case (1'b1)
            pick_lsu: begin
              grant_d    = 2'b10;
              last_lsu_d = 1'b1;
              we_d       = lsu_we;
              wstrb_d    = lsu_wstrb;
              addr_d     = lsu_addr;
              wdata_d    = lsu_data_out;
            end
            default: begin
              grant_d    = 2'b01;
              last_lsu_d = 1'b0;
              we_d       = 1'b0;
              wstrb_d    = '1;
              addr_d     = ifu_addr;
              wdata_d    = '0;
            end
          endcase
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          grant_d = 2'b00;
          cyc_d   = 1'b0;
          to_d    = timeout_o | expire;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q      <= IDLE;
      grant        <= 2'b00;
      last_lsu_q   <= 1'b1;
      cnt_q        <= '0;
      timeout_o    <= 1'b0;
      mem_cyc      <= 1'b0;
      mem_stb      <= 1'b0;
      mem_we       <= 1'b0;
      mem_wstrb    <= '0;
      mem_addr     <= '0;
      mem_data_out <= '0;
    end else begin
      state_q      <= state_d;
      grant        <= grant_d;
      last_lsu_q   <= last_lsu_d;
      cnt_q        <= cnt_d;
      timeout_o    <= to_d;
      mem_cyc      <= cyc_d;
      mem_stb      <= cyc_d;
      mem_we       <= we_d;
      mem_wstrb    <= wstrb_d;
      mem_addr     <= addr_d;
      mem_data_out <= wdata_d;
    end
  end

  // Acks never leak out of IDLE, so a late slave ack is dropped
  assign rsp_data = expire ? ERR_DATA : mem_data_in;

  always_comb begin
    ifu_ack     = 1'b0;
    lsu_ack     = 1'b0;
    ifu_data_in = '0;
    lsu_data_in = '0;
    if (state_q == BUSY) begin
      if (grant[0]) begin
        ifu_ack     = mem_ack | expire;
        ifu_data_in = rsp_data;
      end
      if (grant[1]) begin
        lsu_ack     = mem_ack | expire;
        lsu_data_in = rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: fetch, write, round-robin,
// watchdog expiry, async reset and ack-on-expiry race.
module tb_core_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_core = 1'b0;
  logic          rst_core;
  logic          ifu_cyc, ifu_stb;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_data_in;
  logic          ifu_ack;
  logic          lsu_cyc, lsu_stb, lsu_we;
  logic [3:0]    lsu_wstrb;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_data_out;
  logic [DW-1:0] lsu_data_in;
  logic          lsu_ack;
  logic          mem_cyc, mem_stb, mem_we;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;
  logic          mem_ack;
  logic [1:0]    grant;
  logic          timeout_o;

  int n_tests = 0;
  int n_fail  = 0;
  int ifu_acks = 0;
  int lsu_acks = 0;

  core_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_core(clk_core),
    .rst_core(rst_core),
    .ifu_cyc(ifu_cyc),
    .ifu_stb(ifu_stb),
    .ifu_addr(ifu_addr),
    .ifu_data_in(ifu_data_in),
    .ifu_ack(ifu_ack),
    .lsu_cyc(lsu_cyc),
    .lsu_stb(lsu_stb),
    .lsu_we(lsu_we),
    .lsu_wstrb(lsu_wstrb),
    .lsu_addr(lsu_addr),
    .lsu_data_out(lsu_data_out),
    .lsu_data_in(lsu_data_in),
    .lsu_ack(lsu_ack),
    .mem_cyc(mem_cyc),
    .mem_stb(mem_stb),
    .mem_we(mem_we),
    .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr),
    .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in),
    .mem_ack(mem_ack),
    .grant(grant),
    .timeout_o(timeout_o)
  );

  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) begin
    if (ifu_ack) ifu_acks <= ifu_acks + 1;
    if (lsu_ack) lsu_acks <= lsu_acks + 1;
  end

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ifu_req(input logic on, input logic [AW-1:0] a);
    ifu_cyc  = on;
    ifu_stb  = on;
    ifu_addr = a;
  endtask

  task automatic lsu_req(input logic on, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s);
    lsu_cyc      = on;
    lsu_stb      = on;
    lsu_we       = we;
    lsu_addr     = a;
    lsu_data_out = d;
    lsu_wstrb    = s;
  endtask

  initial begin
    logic [1:0]    exp_g;
    logic [AW-1:0] exp_a;
    rst_core = 1'b1;
    ifu_req(1'b0, '0);
    lsu_req(1'b0, 1'b0, '0, '0, '0);
    mem_ack     = 1'b1;
    mem_data_in = 32'h11111111;
    #1;
    chk("rst_mem_cyc", 64'(mem_cyc), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_ifu_ack", 64'(ifu_ack), 64'd0);
    chk("rst_lsu_data", 64'(lsu_data_in), 64'd0);
    mem_ack = 1'b0;
    step();
    step();
    rst_core = 1'b0;
    step();

    // single fetch
    ifu_req(1'b1, 32'h100);
    step();
    chk("f_cyc", 64'(mem_cyc), 64'd1);
    chk("f_stb", 64'(mem_stb), 64'd1);
    chk("f_addr", 64'(mem_addr), 64'h100);
    chk("f_we", 64'(mem_we), 64'd0);
    chk("f_wstrb", 64'(mem_wstrb), 64'hF);
    chk("f_grant", 64'(grant), 64'd1);
    chk("f_noack", 64'(ifu_ack), 64'd0);
    mem_ack     = 1'b1;
    mem_data_in = 32'h00000013;
    #1;
    chk("f_ack", 64'(ifu_ack), 64'd1);
    chk("f_data", 64'(ifu_data_in), 64'h13);
    chk("f_lsu_ack", 64'(lsu_ack), 64'd0);
    chk("f_lsu_data", 64'(lsu_data_in), 64'd0);
    step();
    mem_ack = 1'b0;
    ifu_req(1'b0, '0);
    #1;
    chk("f_idle_cyc", 64'(mem_cyc), 64'd0);
    chk("f_idle_grant", 64'(grant), 64'd0);

    // LSU write, one wait cycle before ack
    ifu_acks = 0;
    lsu_acks = 0;
    lsu_req(1'b1, 1'b1, 32'h2004, 32'hCAFEF00D, 4'b0011);
    step();
    chk("w_grant", 64'(grant), 64'd2);
    chk("w_addr", 64'(mem_addr), 64'h2004);
    chk("w_we", 64'(mem_we), 64'd1);
    chk("w_wstrb", 64'(mem_wstrb), 64'h3);
    chk("w_data", 64'(mem_data_out), 64'hCAFEF00D);
    chk("w_wait_ack", 64'(lsu_ack), 64'd0);
    step();
    mem_ack = 1'b1;
    #1;
    chk("w_ack", 64'(lsu_ack), 64'd1);
    chk("w_ifu_ack", 64'(ifu_ack), 64'd0);
    step();
    mem_ack = 1'b0;
    lsu_req(1'b0, 1'b0, '0, '0, '0);
    step();
    step();
    chk("w_lsu_pulses", 64'(lsu_acks), 64'd1);
    chk("w_ifu_pulses", 64'(ifu_acks), 64'd0);
    chk("w_idle_cyc", 64'(mem_cyc), 64'd0);

    // simultaneous requests from reset
    rst_core = 1'b1;
    step();
    rst_core = 1'b0;
    ifu_req(1'b1, 32'h200);
    lsu_req(1'b1, 1'b0, 32'h300, '0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 32'h200 : 32'h300;
      step();
      chk("rr_grant", 64'(grant), 64'(exp_g));
      chk("rr_addr", 64'(mem_addr), 64'(exp_a));
      mem_ack     = 1'b1;
      mem_data_in = 32'hA0 + 32'(i);
      #1;
      chk("rr_ifu_ack", 64'(ifu_ack), 64'(exp_g[0]));
      chk("rr_lsu_ack", 64'(lsu_ack), 64'(exp_g[1]));
      step();
      mem_ack = 1'b0;
      if (i == 3) begin
        ifu_req(1'b0, '0);
        lsu_req(1'b0, 1'b0, '0, '0, '0);
      end
      chk("rr_idle", 64'(mem_cyc), 64'd0);
    end
    step();

    // watchdog expiry on LSU read
    lsu_req(1'b1, 1'b0, 32'h400, '0, 4'hF);
    step();
    chk("to_grant", 64'(grant), 64'd2);
    for (int k = 1; k < 8; k++) begin
      chk("to_early_ack", 64'(lsu_ack), 64'd0);
      step();
    end
    chk("to_flag_before", 64'(timeout_o), 64'd0);
    chk("to_ack", 64'(lsu_ack), 64'd1);
    chk("to_data", 64'(lsu_data_in), 64'hDEADBEEF);
    lsu_req(1'b0, 1'b0, '0, '0, '0);
    step();
    chk("to_idle", 64'(mem_cyc), 64'd0);
    chk("to_flag", 64'(timeout_o), 64'd1);
    mem_ack     = 1'b1;
    mem_data_in = 32'h55;
    #1;
    chk("to_late_ack", 64'(lsu_ack), 64'd0);
    chk("to_late_data", 64'(lsu_data_in), 64'd0);
    chk("to_late_ifu", 64'(ifu_ack), 64'd0);
    step();
    mem_ack = 1'b0;
    chk("to_sticky", 64'(timeout_o), 64'd1);
    chk("to_still_idle", 64'(mem_cyc), 64'd0);

    // reset mid-transaction
    ifu_req(1'b1, 32'h500);
    step();
    chk("mr_grant", 64'(grant), 64'd1);
    #2;
    rst_core = 1'b1;
    #1;
    chk("mr_cyc", 64'(mem_cyc), 64'd0);
    chk("mr_grant0", 64'(grant), 64'd0);
    chk("mr_timeout", 64'(timeout_o), 64'd0);
    chk("mr_addr", 64'(mem_addr), 64'd0);
    lsu_req(1'b1, 1'b0, 32'h600, '0, 4'hF);
    step();
    rst_core = 1'b0;
    step();
    chk("mr_first", 64'(grant), 64'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    ifu_req(1'b0, '0);
    lsu_req(1'b0, 1'b0, '0, '0, '0);
    step();

    // slave ack lands on the expiry cycle
    ifu_req(1'b1, 32'h700);
    step();
    chk("ae_grant", 64'(grant), 64'd1);
    for (int k = 1; k < 8; k++) step();
    mem_ack     = 1'b1;
    mem_data_in = 32'h12345678;
    #1;
    chk("ae_ack", 64'(ifu_ack), 64'd1);
    chk("ae_data", 64'(ifu_data_in), 64'h12345678);
    ifu_req(1'b0, '0);
    step();
    mem_ack = 1'b0;
    chk("ae_idle", 64'(mem_cyc), 64'd0);
    chk("ae_timeout", 64'(timeout_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
